// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcodes, state encoding and output codes for the multicycle control FSM
package mips_ctrl_pkg;

  // Instruction bits [31:26] recognised by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_EXEC_ADDR,
    ST_EXEC_BR,
    ST_JUMP,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB_ALU,
    ST_WB_MEM,
    ST_TRAP
  } state_t;

  localparam logic [2:0] ALU_IDLE   = 3'b000;
  localparam logic [2:0] ALU_FUNCT  = 3'b001;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_BRANCH = 3'b100;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Bit positions of the one-hot instruction class
  localparam int CLS_R    = 0;
  localparam int CLS_IMM  = 1;
  localparam int CLS_LW   = 2;
  localparam int CLS_SW   = 3;
  localparam int CLS_BEQ  = 4;
  localparam int CLS_BNE  = 5;
  localparam int CLS_BGTZ = 6;
  localparam int CLS_J    = 7;
  localparam int CLS_ILL  = 8;
  localparam int CLS_W    = 9;

endpackage

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational opcode classifier producing a one-hot instruction class
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic [5:0]       i_opcode,
  output logic [CLS_W-1:0] o_class
);

  // Exactly one class bit is set for every opcode; j falls back to illegal when disabled
  always_comb begin
    o_class = '0;
    case (i_opcode)
      OP_RTYPE: o_class[CLS_R]    = 1'b1;
      OP_ADDI:  o_class[CLS_IMM]  = 1'b1;
      OP_LW:    o_class[CLS_LW]   = 1'b1;
      OP_SW:    o_class[CLS_SW]   = 1'b1;
      OP_BEQ:   o_class[CLS_BEQ]  = 1'b1;
      OP_BNE:   o_class[CLS_BNE]  = 1'b1;
      OP_BGTZ:  o_class[CLS_BGTZ] = 1'b1;
      OP_J: begin
        if (ENABLE_JUMP) o_class[CLS_J] = 1'b1;
        else             o_class[CLS_ILL] = 1'b1;
      end
      default:  o_class[CLS_ILL]  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM sharing one memory port, with illegal/timeout trap
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit ENABLE_JUMP = 1'b1,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_iord,
  output logic       o_ir_write,
  output logic       o_pc_inc,
  output logic       o_pc_jump,
  output logic       o_reg_write,
  output logic       o_reg_dst,
  output logic       o_data_in_sel,
  output logic       o_alu_b_sel,
  output logic       o_ext_op,
  output logic [2:0] o_alu_op,
  output logic       o_branch_en,
  output logic       o_beq_en,
  output logic       o_bne_en,
  output logic       o_bgtz_en,
  output logic       o_retire,
  output logic       o_trap,
  output logic [1:0] o_trap_cause
);

  // Counter must hold 0..MEM_TIMEOUT; keep one bit when the timeout is disabled
  localparam int              CNT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

  state_t           r_state;
  state_t           w_state_next;
  logic [5:0]       r_opcode_q;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_inc;
  logic [1:0]       r_trap_cause;
  logic [1:0]       w_trap_cause_next;
  logic [CLS_W-1:0] w_class;
  logic             w_mem_state;
  logic             w_waiting;
  logic             w_timeout;

  mips_ctrl_decode #(
    .ENABLE_JUMP(ENABLE_JUMP)
  ) u_decode (
    .i_opcode(r_opcode_q),
    .o_class (w_class)
  );

  assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
  assign w_waiting   = (MEM_TIMEOUT != 0) && w_mem_state && !i_mem_ready;
  assign w_wait_inc  = r_wait_cnt + CNT_W'(1);
  // This wait cycle is the one that brings the count up to the limit; a ready in it wins
  assign w_timeout   = w_waiting && (w_wait_inc == CNT_LIMIT);

  // State and trap cause; both drop asynchronously on reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_RESET;
      r_trap_cause <= CAUSE_NONE;
    end else begin
      r_state      <= w_state_next;
      r_trap_cause <= w_trap_cause_next;
    end
  end

  // Opcode capture on fetch completion and per-access wait counter (zero outside a wait)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_opcode_q <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (r_state == ST_FETCH && i_mem_ready) r_opcode_q <= i_opcode;
      if (w_waiting) r_wait_cnt <= w_wait_inc;
      else           r_wait_cnt <= '0;
    end
  end

  // Next-state and datapath controls; only ir_write/pc_inc/retire depend on mem_ready
  always_comb begin
    w_state_next      = r_state;
    w_trap_cause_next = r_trap_cause;
    o_mem_req         = 1'b0;
    o_mem_we          = 1'b0;
    o_iord            = 1'b0;
    o_ir_write        = 1'b0;
    o_pc_inc          = 1'b0;
    o_pc_jump         = 1'b0;
    o_reg_write       = 1'b0;
    o_reg_dst         = 1'b0;
    o_data_in_sel     = 1'b0;
    o_alu_b_sel       = 1'b0;
    o_ext_op          = 1'b1;
    o_alu_op          = ALU_IDLE;
    o_branch_en       = 1'b0;
    o_beq_en          = 1'b0;
    o_bne_en          = 1'b0;
    o_bgtz_en         = 1'b0;
    o_retire          = 1'b0;
    o_trap            = 1'b0;
    o_trap_cause      = CAUSE_NONE;
    case (r_state)
      ST_RESET: w_state_next = ST_FETCH;
      ST_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_ir_write   = 1'b1;
          o_pc_inc     = 1'b1;
          w_state_next = ST_DECODE;
        end else if (w_timeout) begin
          w_state_next      = ST_TRAP;
          w_trap_cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (w_class[CLS_R])                                             w_state_next = ST_EXEC_R;
        else if (w_class[CLS_IMM] || w_class[CLS_LW] || w_class[CLS_SW]) w_state_next = ST_EXEC_ADDR;
        else if (w_class[CLS_BEQ] || w_class[CLS_BNE] || w_class[CLS_BGTZ]) w_state_next = ST_EXEC_BR;
        else if (w_class[CLS_J])                                        w_state_next = ST_JUMP;
        else if (w_class[CLS_ILL]) begin
          w_state_next      = ST_TRAP;
          w_trap_cause_next = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC_R: begin
        o_alu_op     = ALU_FUNCT;
        w_state_next = ST_WB_ALU;
      end
      ST_EXEC_ADDR: begin
        o_alu_op    = ALU_ADD;
        o_alu_b_sel = 1'b1;
        if (w_class[CLS_LW])      w_state_next = ST_MEM_RD;
        else if (w_class[CLS_SW]) w_state_next = ST_MEM_WR;
        else                      w_state_next = ST_WB_ALU;
      end
      ST_MEM_RD, ST_MEM_WR: begin
        o_mem_req   = 1'b1;
        o_iord      = 1'b1;
        o_alu_b_sel = 1'b1;
        o_alu_op    = ALU_ADD;
        o_mem_we    = (r_state == ST_MEM_WR);
        if (i_mem_ready) begin
          o_retire     = (r_state == ST_MEM_WR);
          w_state_next = (r_state == ST_MEM_WR) ? ST_FETCH : ST_WB_MEM;
        end else if (w_timeout) begin
          w_state_next      = ST_TRAP;
          w_trap_cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_WB_ALU: begin
        o_reg_write  = 1'b1;
        o_reg_dst    = w_class[CLS_R];
        o_retire     = 1'b1;
        w_state_next = ST_FETCH;
      end
      ST_WB_MEM: begin
        o_reg_write   = 1'b1;
        o_data_in_sel = 1'b1;
        o_retire      = 1'b1;
        w_state_next  = ST_FETCH;
      end
      ST_EXEC_BR: begin
        o_alu_op     = ALU_BRANCH;
        o_branch_en  = 1'b1;
        o_beq_en     = w_class[CLS_BEQ];
        o_bne_en     = w_class[CLS_BNE];
        o_bgtz_en    = w_class[CLS_BGTZ];
        o_retire     = 1'b1;
        w_state_next = ST_FETCH;
      end
      ST_JUMP: begin
        o_pc_jump    = 1'b1;
        o_retire     = 1'b1;
        w_state_next = ST_FETCH;
      end
      ST_TRAP: begin
        o_trap       = 1'b1;
        o_trap_cause = r_trap_cause;
      end
      default: w_state_next = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench: directed and random instruction streams against a cycle-sequence model
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_inc;
    logic       pc_jump;
    logic       reg_write;
    logic       reg_dst;
    logic       data_in_sel;
    logic       alu_b_sel;
    logic       ext_op;
    logic [2:0] alu_op;
    logic       branch_en;
    logic       beq_en;
    logic       bne_en;
    logic       bgtz_en;
    logic       retire;
    logic       trap;
    logic [1:0] trap_cause;
  } outs_t;

  localparam logic [5:0] R_OP = 6'b000000, J_OP = 6'b000010, BEQ_OP = 6'b000100, BNE_OP = 6'b000101;
  localparam logic [5:0] BGTZ_OP = 6'b000111, ADDI_OP = 6'b001000, LW_OP = 6'b100011, SW_OP = 6'b101011;

  logic       clk;
  logic       rst_n  [2];
  logic [5:0] opcode [2];
  logic       ready  [2];
  wire  [21:0] ov    [2];

  int    n_pass = 0;
  int    n_fail = 0;
  int    n_total = 0;
  string ctx = "init";

  // Instance 0: j enabled, no timeout.  Instance 1: j illegal, MEM_TIMEOUT = 4.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mips_multicycle_ctrl #(
      .ENABLE_JUMP(g == 0),
      .MEM_TIMEOUT((g == 0) ? 0 : 4)
    ) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n[g]),
      .i_opcode     (opcode[g]),
      .i_mem_ready  (ready[g]),
      .o_mem_req    (ov[g][21]),
      .o_mem_we     (ov[g][20]),
      .o_iord       (ov[g][19]),
      .o_ir_write   (ov[g][18]),
      .o_pc_inc     (ov[g][17]),
      .o_pc_jump    (ov[g][16]),
      .o_reg_write  (ov[g][15]),
      .o_reg_dst    (ov[g][14]),
      .o_data_in_sel(ov[g][13]),
      .o_alu_b_sel  (ov[g][12]),
      .o_ext_op     (ov[g][11]),
      .o_alu_op     (ov[g][10:8]),
      .o_branch_en  (ov[g][7]),
      .o_beq_en     (ov[g][6]),
      .o_bne_en     (ov[g][5]),
      .o_bgtz_en    (ov[g][4]),
      .o_retire     (ov[g][3]),
      .o_trap       (ov[g][2]),
      .o_trap_cause (ov[g][1:0])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic outs_t get_obs(input int d);
    return outs_t'(ov[d]);
  endfunction

  function automatic int tmo(input int d);
    return (d == 0) ? 0 : 4;
  endfunction

  function automatic bit jump_ok(input int d);
    return d == 0;
  endfunction

  function automatic outs_t idle();
    outs_t o;
    o = '0;
    o.ext_op = 1'b1;
    return o;
  endfunction

  task automatic check(input string tag, input outs_t obs, input outs_t exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s [%s] observed=%h expected=%h", tag, ctx, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare shortly after
  task automatic step(input int d, input logic rdy, input logic [5:0] op, input outs_t e, input string tag);
    @(negedge clk);
    ready[d]  = rdy;
    opcode[d] = op;
    #1;
    check(tag, get_obs(d), e);
  endtask

  task automatic quiet(input int d, input outs_t e, input string tag);
    step(d, 1'($urandom), 6'($urandom), e, tag);
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    #2;
    rst_n[d] = 1'b0;
    ready[d] = 1'b1;
    #1;
    check("reset_async", get_obs(d), idle());
    @(negedge clk);
    rst_n[d] = 1'b1;
    #1;
    check("reset_state", get_obs(d), idle());
  endtask

  task automatic trap_tail(input int d, input logic [1:0] cause, input string tag);
    outs_t e;
    e = idle();
    e.trap = 1'b1;
    e.trap_cause = cause;
    for (int k = 0; k < 3; k++) quiet(d, e, tag);
  endtask

  // A memory access that needs w wait cycles; with a limit it gives up after exactly lim waits
  task automatic mem_access(input int d, input outs_t busy, input outs_t done, input int w,
                            input logic [5:0] op, input string tag, output bit timed_out);
    int lim;
    lim = tmo(d);
    timed_out = (lim != 0) && (w >= lim);
    for (int k = 0; k < (timed_out ? lim : w); k++) step(d, 1'b0, 6'($urandom), busy, tag);
    if (!timed_out) step(d, 1'b1, op, done, tag);
  endtask

  task automatic run_instr(input int d, input logic [5:0] op, input int fw, input int mw, output bit trapped);
    outs_t e, busy, done;
    bit    to;
    trapped = 1'b0;
    busy = idle();
    busy.mem_req = 1'b1;
    done = busy;
    done.ir_write = 1'b1;
    done.pc_inc = 1'b1;
    mem_access(d, busy, done, fw, op, "fetch", to);
    if (to) begin
      trap_tail(d, 2'b10, "trap_fetch_timeout");
      trapped = 1'b1;
      return;
    end
    quiet(d, idle(), "decode");
    case (op)
      R_OP: begin
        e = idle(); e.alu_op = 3'b001;
        quiet(d, e, "exec_r");
        e = idle(); e.reg_write = 1'b1; e.reg_dst = 1'b1; e.retire = 1'b1;
        quiet(d, e, "wb_r");
      end
      ADDI_OP, LW_OP, SW_OP: begin
        e = idle(); e.alu_op = 3'b010; e.alu_b_sel = 1'b1;
        quiet(d, e, "exec_addr");
        if (op == ADDI_OP) begin
          e = idle(); e.reg_write = 1'b1; e.retire = 1'b1;
          quiet(d, e, "wb_addi");
        end else begin
          busy = idle(); busy.mem_req = 1'b1; busy.iord = 1'b1; busy.alu_b_sel = 1'b1;
          busy.alu_op = 3'b010; busy.mem_we = (op == SW_OP);
          done = busy;
          done.retire = (op == SW_OP);
          mem_access(d, busy, done, mw, 6'($urandom), (op == SW_OP) ? "mem_wr" : "mem_rd", to);
          if (to) begin
            trap_tail(d, 2'b10, "trap_mem_timeout");
            trapped = 1'b1;
            return;
          end
          if (op == LW_OP) begin
            e = idle(); e.reg_write = 1'b1; e.data_in_sel = 1'b1; e.retire = 1'b1;
            quiet(d, e, "wb_mem");
          end
        end
      end
      BEQ_OP, BNE_OP, BGTZ_OP: begin
        e = idle(); e.alu_op = 3'b100; e.branch_en = 1'b1; e.retire = 1'b1;
        e.beq_en = (op == BEQ_OP); e.bne_en = (op == BNE_OP); e.bgtz_en = (op == BGTZ_OP);
        quiet(d, e, "exec_br");
      end
      J_OP: begin
        if (jump_ok(d)) begin
          e = idle(); e.pc_jump = 1'b1; e.retire = 1'b1;
          quiet(d, e, "jump");
        end else begin
          trap_tail(d, 2'b01, "trap_j_disabled");
          trapped = 1'b1;
        end
      end
      default: begin
        trap_tail(d, 2'b01, "trap_illegal");
        trapped = 1'b1;
      end
    endcase
  endtask

  task automatic exec_instr(input int d, input logic [5:0] op, input int fw, input int mw);
    bit tr;
    ctx = $sformatf("dut%0d op=%b fw=%0d mw=%0d", d, op, fw, mw);
    run_instr(d, op, fw, mw, tr);
    if (tr) do_reset(d);
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [8];
    int r;
    tbl = '{R_OP, ADDI_OP, LW_OP, SW_OP, BEQ_OP, BNE_OP, BGTZ_OP, J_OP};
    r = int'($urandom_range(0, 10));
    return (r < 8) ? tbl[r] : 6'($urandom);
  endfunction

  initial begin
    outs_t e;
    rst_n  = '{1'b0, 1'b0};
    ready  = '{1'b0, 1'b0};
    opcode = '{6'd0, 6'd0};

    // Instance 0: zero-wait R-type, lw with 3 waits, bne, j, then the rest
    do_reset(0);
    exec_instr(0, R_OP, 0, 0);
    exec_instr(0, LW_OP, 0, 3);
    exec_instr(0, BNE_OP, 0, 0);
    exec_instr(0, J_OP, 0, 0);
    exec_instr(0, ADDI_OP, 2, 0);
    exec_instr(0, SW_OP, 1, 2);
    exec_instr(0, BEQ_OP, 0, 0);
    exec_instr(0, BGTZ_OP, 3, 0);
    exec_instr(0, 6'b111111, 0, 0);

    // Reset landing in the middle of a lw data wait, then normal fetch resumes
    ctx = "dut0 reset mid MEM_RD";
    e = idle(); e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_inc = 1'b1;
    step(0, 1'b1, LW_OP, e, "fetch");
    quiet(0, idle(), "decode");
    e = idle(); e.alu_op = 3'b010; e.alu_b_sel = 1'b1;
    quiet(0, e, "exec_addr");
    e = idle(); e.mem_req = 1'b1; e.iord = 1'b1; e.alu_b_sel = 1'b1; e.alu_op = 3'b010;
    step(0, 1'b0, 6'($urandom), e, "mem_rd");
    step(0, 1'b0, 6'($urandom), e, "mem_rd");
    do_reset(0);
    exec_instr(0, R_OP, 0, 0);

    for (int i = 0; i < 40; i++)
      exec_instr(0, pick_op(), int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));

    // Instance 1: j illegal, timeout boundaries on data and fetch accesses
    do_reset(1);
    exec_instr(1, J_OP, 0, 0);
    exec_instr(1, SW_OP, 0, 4);
    exec_instr(1, SW_OP, 0, 3);
    exec_instr(1, LW_OP, 3, 3);
    exec_instr(1, R_OP, 4, 0);
    exec_instr(1, ADDI_OP, 0, 0);

    for (int i = 0; i < 40; i++)
      exec_instr(1, pick_op(), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
